demux_1xn_striper: RTL and testbench

//  Parametrised 1-to-N byte un-striper on a single clock; generalises the fixed 1x4 8-bit demux.

---
 rtl/demux_1xn_striper.sv | 193 +++++++++++++++++++
 tb/tb_demux_1xn_striper.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1xn_striper.sv
// demux_1xn_striper: collects a serial word stream round-robin into LANES lanes and
// emits each group as one parallel word. Optional statistics counters: DEMUX_STATS_EN.
module demux_1xn_striper #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int PTR_W      = $clog2(LANES)
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_lane_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PTR_W-1:0]            fill_ptr
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]                 grp_cnt,
    output logic [7:0]                  flush_cnt
`endif
);

    localparam int              OUT_W    = LANES * DATA_WIDTH;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANES - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_r;
    logic               in_ready_r;
    logic [OUT_W-1:0]   asm_r;
    logic [LANES-1:0]   mask_r;
    logic [PTR_W-1:0]   fill_ptr_r;
    logic [OUT_W-1:0]   out_data_r;
    logic [LANES-1:0]   out_mask_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               out_free_s;
    logic               last_s;
    logic               emit_s;
    logic               load_s;
    logic [OUT_W-1:0]   asm_next_s;
    logic [LANES-1:0]   mask_next_s;
    logic [OUT_W-1:0]   load_data_s;
    logic [LANES-1:0]   load_mask_s;
    logic [PTR_W-1:0]   ptr_inc_s;

    assign in_ready      = in_ready_r;
    assign out_data      = out_data_r;
    assign out_lane_mask = out_mask_r;
    assign out_valid     = out_valid_r;
    assign fill_ptr      = fill_ptr_r;

    // Next assembly contents and the emit/load decisions for this cycle
    always_comb begin
        accept_s    = in_valid & in_ready_r;
        out_free_s  = ~out_valid_r | out_ready;
        asm_next_s  = asm_r;
        mask_next_s = mask_r;
        for (int i = 0; i < LANES; i++) begin
            if (accept_s && (fill_ptr_r == PTR_W'(i))) begin
                asm_next_s[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
                mask_next_s[i]                         = 1'b1;
            end else begin
                asm_next_s[i*DATA_WIDTH +: DATA_WIDTH] = asm_r[i*DATA_WIDTH +: DATA_WIDTH];
                mask_next_s[i]                         = mask_r[i];
            end
        end
        last_s = accept_s & (fill_ptr_r == LAST_PTR);
        if (fill_ptr_r == LAST_PTR) begin
            ptr_inc_s = {PTR_W{1'b0}};
        end else begin
            ptr_inc_s = fill_ptr_r + PTR_W'(1);
        end
        emit_s      = 1'b0;
        load_s      = 1'b0;
        load_data_s = asm_next_s;
        load_mask_s = mask_next_s;
        case (state_r)
            ST_FILL: begin
                emit_s = last_s | (flush & (|mask_next_s));
                load_s = emit_s & out_free_s;
            end
            ST_HOLD: begin
                load_s      = out_free_s;
                load_data_s = asm_r;
                load_mask_s = mask_r;
            end
            default: begin
                emit_s = 1'b0;
                load_s = 1'b0;
            end
        endcase
    end

    // Assembly buffer, lane pointer and FILL/HOLD state machine
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r    <= ST_FILL;
            in_ready_r <= 1'b1;
            asm_r      <= {OUT_W{1'b0}};
            mask_r     <= {LANES{1'b0}};
            fill_ptr_r <= {PTR_W{1'b0}};
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (emit_s && out_free_s) begin
                        asm_r      <= {OUT_W{1'b0}};
                        mask_r     <= {LANES{1'b0}};
                        fill_ptr_r <= {PTR_W{1'b0}};
                    end else if (emit_s) begin
                        // Output still occupied: freeze the group until it drains
                        asm_r      <= asm_next_s;
                        mask_r     <= mask_next_s;
                        fill_ptr_r <= accept_s ? ptr_inc_s : fill_ptr_r;
                        state_r    <= ST_HOLD;
                        in_ready_r <= 1'b0;
                    end else begin
                        asm_r      <= asm_next_s;
                        mask_r     <= mask_next_s;
                        fill_ptr_r <= accept_s ? ptr_inc_s : fill_ptr_r;
                    end
                end
                ST_HOLD: begin
                    if (out_free_s) begin
                        asm_r      <= {OUT_W{1'b0}};
                        mask_r     <= {LANES{1'b0}};
                        fill_ptr_r <= {PTR_W{1'b0}};
                        state_r    <= ST_FILL;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r    <= ST_HOLD;
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_FILL;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Output register: loads a group when free, otherwise holds until consumed
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_data_r  <= {OUT_W{1'b0}};
            out_mask_r  <= {LANES{1'b0}};
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= load_data_s;
            out_mask_r  <= load_mask_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] grp_cnt_r;
    logic [7:0]  flush_cnt_r;

    assign grp_cnt   = grp_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // Group counter wraps; partial-group counter saturates
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            grp_cnt_r   <= 16'h0000;
            flush_cnt_r <= 8'h00;
        end else if (load_s) begin
            grp_cnt_r <= grp_cnt_r + 16'h0001;
            if (!(&load_mask_s) && (flush_cnt_r != 8'hFF)) begin
                flush_cnt_r <= flush_cnt_r + 8'h01;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end else begin
            grp_cnt_r   <= grp_cnt_r;
            flush_cnt_r <= flush_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1xn_striper.sv
// Directed bench for demux_1xn_striper: vector table plus reset, statistics and 8-lane sequences.
module tb_demux_1xn_striper;

    logic         clk = 1'b0;
    logic         reset_L;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [31:0]  out_data;
    logic [3:0]   out_lane_mask;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   fill_ptr;

    logic [15:0]  in8_data;
    logic         in8_valid;
    logic         in8_ready;
    logic         flush8;
    logic [127:0] out8_data;
    logic [7:0]   out8_mask;
    logic         out8_valid;
    logic         out8_ready;
    logic [2:0]   ptr8;

`ifdef DEMUX_STATS_EN
    logic [15:0]  grp_cnt;
    logic [7:0]   flush_cnt;
    logic [15:0]  grp_cnt8;
    logic [7:0]   flush_cnt8;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_1xn_striper #(.DATA_WIDTH(8), .LANES(4)) dut (
        .clk(clk), .reset_L(reset_L),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data), .out_lane_mask(out_lane_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .fill_ptr(fill_ptr)
`ifdef DEMUX_STATS_EN
        , .grp_cnt(grp_cnt), .flush_cnt(flush_cnt)
`endif
    );

    demux_1xn_striper #(.DATA_WIDTH(16), .LANES(8)) dut8 (
        .clk(clk), .reset_L(reset_L),
        .in_data(in8_data), .in_valid(in8_valid), .in_ready(in8_ready),
        .flush(flush8),
        .out_data(out8_data), .out_lane_mask(out8_mask),
        .out_valid(out8_valid), .out_ready(out8_ready),
        .fill_ptr(ptr8)
`ifdef DEMUX_STATS_EN
        , .grp_cnt(grp_cnt8), .flush_cnt(flush_cnt8)
`endif
    );

    typedef struct packed {
        logic        iv;
        logic [7:0]  d;
        logic        fl;
        logic        ord;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_data;
        logic [3:0]  e_mask;
        logic [1:0]  e_ptr;
    } vec_t;

    vec_t vt [32];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] d, input logic fl, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        //            iv   d      fl   ord  rdy  ov   data          mask  ptr
        vt[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd1};
        vt[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd2};
        vt[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd3};
        vt[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA3A2A1A0, 4'hF, 2'd0};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd0};
        vt[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd1};
        vt[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd2};
        vt[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd3};
        vt[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 32'h03020100, 4'hF, 2'd0};
        vt[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 32'h03020100, 4'hF, 2'd1};
        vt[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 32'h03020100, 4'hF, 2'd2};
        vt[11] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 32'h03020100, 4'hF, 2'd3};
        vt[12] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 32'h03020100, 4'hF, 2'd0};
        vt[13] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h03020100, 4'hF, 2'd0};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h07060504, 4'hF, 2'd0};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd0};
        vt[16] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd1};
        vt[17] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd2};
        vt[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00002211, 4'h3, 2'd0};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd0};
        vt[20] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd1};
        vt[21] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd2};
        vt[22] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00332211, 4'h7, 2'd0};
        vt[23] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd0};
        vt[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd0};
        vt[25] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd1};
        vt[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000044, 4'h1, 2'd0};
        vt[27] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000044, 4'h1, 2'd1};
        vt[28] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000044, 4'h1, 2'd1};
        vt[29] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000044, 4'h1, 2'd1};
        vt[30] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000055, 4'h1, 2'd0};
        vt[31] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'h0, 2'd0};

        reset_L    = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        in8_data   = 16'h0000;
        in8_valid  = 1'b0;
        flush8     = 1'b0;
        out8_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst mask", out_lane_mask, 4'h0);
        chk("rst fill_ptr", fill_ptr, 2'd0);
        reset_L = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", in_ready, 1'b1);

        for (int i = 0; i < 32; i++) begin
            send(vt[i].iv, vt[i].d, vt[i].fl, vt[i].ord);
            chk($sformatf("v%0d in_ready", i), in_ready, vt[i].e_rdy);
            chk($sformatf("v%0d out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("v%0d fill_ptr", i), fill_ptr, vt[i].e_ptr);
            if (vt[i].e_ov) begin
                chk($sformatf("v%0d out_data", i), out_data, vt[i].e_data);
                chk($sformatf("v%0d mask", i), out_lane_mask, vt[i].e_mask);
            end
        end

        // Reset in the middle of a group discards the partial words
        send(1'b1, 8'h55, 1'b0, 1'b1);
        send(1'b1, 8'h66, 1'b0, 1'b1);
        chk("pre-rst fill_ptr", fill_ptr, 2'd2);
        in_valid = 1'b0;
        reset_L  = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst out_data", out_data, 32'h0);
        chk("midrst mask", out_lane_mask, 4'h0);
        chk("midrst fill_ptr", fill_ptr, 2'd0);
        @(negedge clk);
        reset_L = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            b = 8'(k);
            send(1'b1, b, 1'b0, 1'b1);
        end
        chk("after-rst out_valid", out_valid, 1'b1);
        chk("after-rst out_data", out_data, 32'h04030201);
        chk("after-rst mask", out_lane_mask, 4'hF);

        // Two more full groups, then two flushed partial groups
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(16 + g * 4 + k);
                send(1'b1, b, 1'b0, 1'b1);
            end
        end
        chk("grp3 out_data", out_data, 32'h17161514);
        send(1'b1, 8'h21, 1'b0, 1'b1);
        send(1'b0, 8'h00, 1'b1, 1'b1);
        chk("part1 out_data", out_data, 32'h00000021);
        chk("part1 mask", out_lane_mask, 4'h1);
        send(1'b1, 8'h31, 1'b0, 1'b1);
        send(1'b1, 8'h32, 1'b1, 1'b1);
        chk("part2 out_data", out_data, 32'h00003231);
        chk("part2 mask", out_lane_mask, 4'h3);
        send(1'b0, 8'h00, 1'b0, 1'b1);
        chk("idle out_valid", out_valid, 1'b0);
`ifdef DEMUX_STATS_EN
        chk("grp_cnt", grp_cnt, 16'd5);
        chk("flush_cnt", flush_cnt, 8'd2);
`endif

        // Eight 16-bit words into the 8-lane instance
        for (int k = 0; k < 8; k++) begin
            in8_data  = 16'h1000 + 16'(k);
            in8_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in8_valid = 1'b0;
        chk("l8 out_valid", out8_valid, 1'b1);
        chk("l8 out_data", out8_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
        chk("l8 mask", out8_mask, 8'hFF);
        chk("l8 fill_ptr", ptr8, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
